// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer_if
//  Description : Bundle between the game sequencer and the piece-movement
//                block. The sequencer (master) publishes its state and the
//                current piece/board; the movement block (slave) answers
//                with the moved board, anchor, rotation and landing flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_sequencer_if;
    logic [2:0]  state;
    logic [31:0] curr_board_state;
    logic [4:0]  curr_piece_location;
    logic [1:0]  curr_piece_rotation;
    logic [1:0]  curr_piece_type;
    logic        touched;
    logic [31:0] new_board_state;
    logic [4:0]  new_location;
    logic [1:0]  new_rotation;

    modport master (
        output state, curr_board_state, curr_piece_location,
               curr_piece_rotation, curr_piece_type,
        input  touched, new_board_state, new_location, new_rotation
    );

    modport slave (
        input  state, curr_board_state, curr_piece_location,
               curr_piece_rotation, curr_piece_type,
        output touched, new_board_state, new_location, new_rotation
    );
endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Top-level game FSM for a 4-column x 8-row board: gravity
//                timing, line clearing, scoring, spawning, game over.
//                Board bit = row*4 + col, row 0 at the top.
//                Optional macro RANDOM_PIECE_EN selects a 4-bit LFSR piece
//                generator instead of the round-robin counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int DROP_TICKS = 8
) (
    input  wire logic          clka,
    input  wire logic          restart,
    game_sequencer_if.master   bus,
    output logic [7:0]         score,
    output logic               game_over
);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_MOVE  = 3'b001;
    localparam logic [2:0] S_WAIT  = 3'b010;
    localparam logic [2:0] S_CHECK = 3'b011;
    localparam logic [2:0] S_CLEAR = 3'b100;
    localparam logic [2:0] S_SPAWN = 3'b101;
    localparam logic [2:0] S_OVER  = 3'b110;

    localparam logic [4:0] c_SPAWN_LOC = 5'd5;
    localparam logic [7:0] c_DROP_LAST = 8'(DROP_TICKS - 1);

    logic [2:0]  r_state, w_next_state;
    logic [31:0] r_board;
    logic [4:0]  r_loc;
    logic [1:0]  r_rot;
    logic [1:0]  r_type;
    logic [7:0]  r_score;
    logic [7:0]  r_drop_cnt;
    logic [2:0]  r_row;
    logic [1:0]  w_next_type;
    logic [31:0] w_footprint;
    logic        w_collide;
    logic        w_row_full;
    logic [31:0] w_shifted;
    logic        w_game_over;

`ifdef RANDOM_PIECE_EN
    logic [3:0] r_lfsr;
    assign w_next_type = r_lfsr[1:0];

    // LFSR x^4+x^3+1, steps once per spawn
    always_ff @(posedge clka) begin
        if (restart)
            r_lfsr <= 4'b1001;
        else if (r_state == S_SPAWN)
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end
`else
    logic [1:0] r_type_ctr;
    assign w_next_type = r_type_ctr;

    // Round-robin piece type, steps once per spawn
    always_ff @(posedge clka) begin
        if (restart)
            r_type_ctr <= 2'b00;
        else if (r_state == S_SPAWN)
            r_type_ctr <= r_type_ctr + 2'b01;
    end
`endif

    // Spawn footprint of the incoming piece and its collision test
    always_comb begin
        w_footprint = 32'h0000_0020;
        case (w_next_type)
            2'b00:   w_footprint = 32'h0000_0020;
            2'b01:   w_footprint = 32'h0000_0022;
            2'b10:   w_footprint = 32'h0000_0066;
            default: w_footprint = 32'h0000_0062;
        endcase
        w_collide = |(w_footprint & r_board);
    end

    // Row-full detection and the board with row r removed (rows above drop)
    always_comb begin
        w_row_full = (r_board[{r_row, 2'b00} +: 4] == 4'hF);
        w_shifted  = r_board;
        for (int i = 1; i < 8; i++) begin
            if (i <= 32'(r_row))
                w_shifted[4*i +: 4] = r_board[4*(i-1) +: 4];
        end
        w_shifted[3:0] = 4'h0;
    end

    // State register
    always_ff @(posedge clka) begin
        if (restart)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_SPAWN;
            S_SPAWN: w_next_state = w_collide ? S_OVER : S_WAIT;
            S_WAIT:  w_next_state = (r_drop_cnt == c_DROP_LAST) ? S_MOVE : S_WAIT;
            S_MOVE:  w_next_state = S_CHECK;
            S_CHECK: w_next_state = bus.touched ? S_CLEAR : S_WAIT;
            S_CLEAR: w_next_state = (!w_row_full && r_row == 3'd0) ? S_SPAWN : S_CLEAR;
            S_OVER:  w_next_state = S_OVER;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_game_over = (r_state == S_OVER);
    end

    // Board, piece, score, drop counter and row pointer datapath
    always_ff @(posedge clka) begin
        if (restart) begin
            r_board    <= 32'h0;
            r_loc      <= c_SPAWN_LOC;
            r_rot      <= 2'b00;
            r_type     <= 2'b00;
            r_score    <= 8'h00;
            r_drop_cnt <= 8'h00;
            r_row      <= 3'd7;
        end else begin
            case (r_state)
                S_SPAWN: begin
                    r_loc  <= c_SPAWN_LOC;
                    r_rot  <= 2'b00;
                    r_type <= w_next_type;
                    if (!w_collide) begin
                        r_board    <= r_board | w_footprint;
                        r_drop_cnt <= 8'h00;
                    end
                end
                S_WAIT: r_drop_cnt <= r_drop_cnt + 8'h01;
                S_CHECK: begin
                    r_board <= bus.new_board_state;
                    r_loc   <= bus.new_location;
                    r_rot   <= bus.new_rotation;
                    if (bus.touched)
                        r_row <= 3'd7;
                    else
                        r_drop_cnt <= 8'h00;
                end
                S_CLEAR: begin
                    // A cleared row is rescanned: the row above has moved into it
                    if (w_row_full) begin
                        r_board <= w_shifted;
                        if (r_score != 8'hFF)
                            r_score <= r_score + 8'h01;
                    end else if (r_row != 3'd0) begin
                        r_row <= r_row - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state               = r_state;
    assign bus.curr_board_state    = r_board;
    assign bus.curr_piece_location = r_loc;
    assign bus.curr_piece_rotation = r_rot;
    assign bus.curr_piece_type     = r_type;
    assign score                   = r_score;
    assign game_over               = w_game_over;

endmodule
`default_nettype wire
